// File: rtl/fwperiph_wb_reg_initiator_pkg.sv
// Shared types and sizing helpers for the multi-port Wishbone register initiator.
package fwperiph_wb_reg_initiator_pkg;

    typedef enum logic [1:0] {
        STATUS_OK      = 2'd0,
        STATUS_ERR     = 2'd1,
        STATUS_TIMEOUT = 2'd2
    } rsp_status_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    function automatic int cnt_width(input int timeout);
        return $clog2(timeout);
    endfunction

    // A single port still needs a one-bit index so every vector stays legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fwperiph_rr_arbiter.sv
// Combinational round-robin pick: first request found after 'last', wrapping modulo N.
module fwperiph_rr_arbiter
    import fwperiph_wb_reg_initiator_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]            req,
    input  logic [idx_width(N)-1:0] last,
    output logic [N-1:0]            gnt,
    output logic [idx_width(N)-1:0] gnt_idx,
    output logic                    any
);
    localparam int IDX_W = idx_width(N);

    logic [IDX_W-1:0] cand [N];
    logic [N-1:0]     hit;

    // cand[gi] is the port sitting gi+1 places after the last winner.
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        assign cand[gi] = IDX_W'((32'(last) + 32'(gi) + 32'd1) % 32'(N));
        assign hit[gi]  = req[cand[gi]];
    end

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (hit[i]) begin
                gnt_idx = cand[i];
                any     = 1'b1;
            end
        end
        gnt[gnt_idx] = any;
    end

endmodule

// File: rtl/fwperiph_wb_reg_initiator_arb.sv
// N command ports arbitrated round-robin onto one Wishbone classic master,
// with per-access bus-hang timeout and a response routed back to the issuer.
module fwperiph_wb_reg_initiator_arb
    import fwperiph_wb_reg_initiator_pkg::*;
#(
    parameter int N_INITIATORS = 2,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int TIMEOUT      = 256
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic [N_INITIATORS-1:0]             req_valid,
    output logic [N_INITIATORS-1:0]             req_ready,
    input  logic [N_INITIATORS-1:0]             req_we,
    input  logic [N_INITIATORS*ADDR_WIDTH-1:0]  req_adr,
    input  logic [N_INITIATORS*DATA_WIDTH-1:0]  req_dat,
    input  logic [N_INITIATORS*DATA_WIDTH/8-1:0] req_sel,
    output logic [N_INITIATORS-1:0]             rsp_valid,
    input  logic [N_INITIATORS-1:0]             rsp_ready,
    output logic [DATA_WIDTH-1:0]               rsp_dat,
    output logic [1:0]                          rsp_status,
    output logic [ADDR_WIDTH-1:0]               wb_adr,
    output logic [DATA_WIDTH-1:0]               wb_dat_w,
    input  logic [DATA_WIDTH-1:0]               wb_dat_r,
    output logic [DATA_WIDTH/8-1:0]             wb_sel,
    output logic                                wb_we,
    output logic                                wb_cyc,
    output logic                                wb_stb,
    input  logic                                wb_ack,
    input  logic                                wb_err
);
    localparam int IDX_W = idx_width(N_INITIATORS);
    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_INITIATORS - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  rr_last_q, rr_last_d;
    logic [IDX_W-1:0]  gnt_q, gnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] wb_adr_q, wb_adr_d;
    logic [DATA_WIDTH-1:0] wb_dat_w_q, wb_dat_w_d;
    logic [SEL_W-1:0]  wb_sel_q, wb_sel_d;
    logic              wb_we_q, wb_we_d;
    logic              wb_cyc_q, wb_cyc_d;
    logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
    rsp_status_e       rsp_status_q, rsp_status_d;
    logic              term;

    logic [N_INITIATORS-1:0] arb_gnt;
    logic [IDX_W-1:0]        arb_idx;
    logic                    arb_any;

    fwperiph_rr_arbiter #(.N(N_INITIATORS)) u_arb (
        .req     (req_valid),
        .last    (rr_last_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            rr_last_q    <= LAST_RST;
            gnt_q        <= '0;
            cnt_q        <= '0;
            wb_adr_q     <= '0;
            wb_dat_w_q   <= '0;
            wb_sel_q     <= '0;
            wb_we_q      <= 1'b0;
            wb_cyc_q     <= 1'b0;
            rsp_dat_q    <= '0;
            rsp_status_q <= STATUS_OK;
        end else begin
            state_q      <= state_d;
            rr_last_q    <= rr_last_d;
            gnt_q        <= gnt_d;
            cnt_q        <= cnt_d;
            wb_adr_q     <= wb_adr_d;
            wb_dat_w_q   <= wb_dat_w_d;
            wb_sel_q     <= wb_sel_d;
            wb_we_q      <= wb_we_d;
            wb_cyc_q     <= wb_cyc_d;
            rsp_dat_q    <= rsp_dat_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_last_d    = rr_last_q;
        gnt_d        = gnt_q;
        cnt_d        = cnt_q;
        wb_adr_d     = wb_adr_q;
        wb_dat_w_d   = wb_dat_w_q;
        wb_sel_d     = wb_sel_q;
        wb_we_d      = wb_we_q;
        wb_cyc_d     = wb_cyc_q;
        rsp_dat_d    = rsp_dat_q;
        rsp_status_d = rsp_status_q;
        term         = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    gnt_d      = arb_idx;
                    wb_adr_d   = req_adr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    wb_dat_w_d = req_dat[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
                    wb_sel_d   = req_sel[int'(arb_idx)*SEL_W +: SEL_W];
                    wb_we_d    = req_we[arb_idx];
                    wb_cyc_d   = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_BUS;
                end
            end
            ST_BUS: begin
                cnt_d = cnt_q + CNT_W'(1);
                // err beats ack, and either beats a timeout landing on the same cycle.
                if (wb_err) begin
                    rsp_status_d = STATUS_ERR;
                    rsp_dat_d    = '0;
                    term         = 1'b1;
                end else if (wb_ack) begin
                    rsp_status_d = STATUS_OK;
                    rsp_dat_d    = wb_we_q ? '0 : wb_dat_r;
                    term         = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_status_d = STATUS_TIMEOUT;
                    rsp_dat_d    = '0;
                    term         = 1'b1;
                end
                if (term) begin
                    wb_cyc_d = 1'b0;
                    state_d  = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready[gnt_q]) begin
                    rr_last_d = gnt_q;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (state_q == ST_IDLE) req_ready = arb_gnt;
        if (state_q == ST_RSP)  rsp_valid[gnt_q] = 1'b1;
    end

    assign wb_adr     = wb_adr_q;
    assign wb_dat_w   = wb_dat_w_q;
    assign wb_sel     = wb_sel_q;
    assign wb_we      = wb_we_q;
    assign wb_cyc     = wb_cyc_q;
    assign wb_stb     = wb_cyc_q;
    assign rsp_dat    = rsp_dat_q;
    assign rsp_status = rsp_status_q;

endmodule

// File: tb/tb_fwperiph_wb_reg_initiator_arb.sv
// Scoreboard bench: commands push expected bus accesses and responses; monitors pop and compare.
module tb_fwperiph_wb_reg_initiator_arb;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 16;
    localparam int M_NONE = 0, M_ACK = 1, M_ERR = 2, M_ACKERR = 3;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid, rsp_rdy;
    logic [N*AW-1:0] req_adr;
    logic [N*DW-1:0] req_dat;
    logic [N*SW-1:0] req_sel;
    logic [DW-1:0]   rsp_dat, wb_dat_w, wb_dat_r;
    logic [1:0]      rsp_status;
    logic [AW-1:0]   wb_adr;
    logic [SW-1:0]   wb_sel;
    logic            wb_we, wb_cyc, wb_stb, slave_ack, slave_err, inj_ack;

    fwperiph_wb_reg_initiator_arb #(
        .N_INITIATORS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_rdy),
        .rsp_dat(rsp_dat), .rsp_status(rsp_status),
        .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r),
        .wb_sel(wb_sel), .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_stb(wb_stb),
        .wb_ack(slave_ack | inj_ack), .wb_err(slave_err)
    );

    typedef struct { int port; logic we; logic [AW-1:0] adr; logic [DW-1:0] dat; logic [SW-1:0] sel; } cmd_t;
    typedef struct { logic [AW-1:0] adr; logic we; logic [DW-1:0] dat; logic [SW-1:0] sel; int len; } bus_t;
    typedef struct { int port; logic [DW-1:0] dat; logic [1:0] status; } rsp_t;

    cmd_t cmd_q[$];
    bus_t bus_exp[$];
    rsp_t rsp_exp[$];
    int n_tests = 0;
    int n_fail  = 0;

    int          slave_mode, slave_delay;
    logic [DW-1:0] slave_rdata;
    bit          slave_rd_adr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // len = 0 means the access is cut short (reset) and its length is not checked.
    task automatic push_cmd(input int p, input logic we, input logic [AW-1:0] adr,
                            input logic [DW-1:0] dat, input logic [SW-1:0] sel, input int len,
                            input bit has_rsp, input logic [DW-1:0] edat, input logic [1:0] est);
        cmd_q.push_back('{port: p, we: we, adr: adr, dat: dat, sel: sel});
        bus_exp.push_back('{adr: adr, we: we, dat: dat, sel: sel, len: len});
        if (has_rsp) rsp_exp.push_back('{port: p, dat: edat, status: est});
        $display("[TB] issue port %0d %s adr=0x%08h dat=0x%08h sel=0x%0h", p, we ? "WR" : "RD", adr, dat, sel);
    endtask

    task automatic wait_quiet(input string name);
        int t = 0;
        while (t < 400 && !(cmd_q.size() == 0 && bus_exp.size() == 0 && rsp_exp.size() == 0 &&
                            req_valid == '0 && !wb_cyc && rsp_valid == '0)) begin
            @(posedge clock); #1;
            t++;
        end
        check({name, "_drained"}, 64'(t < 400), 64'd1);
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic wait_cyc(input logic level, input string name);
        int t = 0;
        while (t < 100 && wb_cyc !== level) begin
            @(posedge clock); #1;
            t++;
        end
        check(name, 64'(wb_cyc), 64'(level));
    endtask

    // Command driver: the only writer of req_*; each port presents its oldest command.
    initial begin : driver
        logic [N-1:0] fire, busy;
        cmd_t rest[$];
        req_valid = '0; req_we = '0; req_adr = '0; req_dat = '0; req_sel = '0;
        forever begin
            @(negedge clock);
            fire = req_valid & req_ready;
            @(posedge clock); #1;
            req_valid = req_valid & ~fire;
            busy = req_valid;
            rest.delete();
            foreach (cmd_q[i]) begin
                if (!busy[cmd_q[i].port]) begin
                    req_valid[cmd_q[i].port]            = 1'b1;
                    req_we[cmd_q[i].port]               = cmd_q[i].we;
                    req_adr[cmd_q[i].port*AW +: AW]     = cmd_q[i].adr;
                    req_dat[cmd_q[i].port*DW +: DW]     = cmd_q[i].dat;
                    req_sel[cmd_q[i].port*SW +: SW]     = cmd_q[i].sel;
                    busy[cmd_q[i].port]                 = 1'b1;
                end else begin
                    rest.push_back(cmd_q[i]);
                end
            end
            cmd_q = rest;
        end
    end

    // Wishbone slave: answers on the slave_delay-th cycle of the access.
    initial begin : slave
        int bc;
        bc = 0; slave_ack = 1'b0; slave_err = 1'b0; wb_dat_r = '0;
        forever begin
            @(posedge clock); #1;
            bc = wb_cyc ? bc + 1 : 0;
            slave_ack = 1'b0;
            slave_err = 1'b0;
            if (wb_cyc && bc == slave_delay) begin
                slave_ack = (slave_mode == M_ACK || slave_mode == M_ACKERR);
                slave_err = (slave_mode == M_ERR || slave_mode == M_ACKERR);
                wb_dat_r  = slave_rd_adr ? ~wb_adr : slave_rdata;
            end
        end
    end

    initial begin : monitor
        logic prev_cyc;
        int len, exp_len, p;
        bus_t b;
        rsp_t r;
        prev_cyc = 1'b0; len = 0; exp_len = 0;
        forever begin
            @(negedge clock);
            if (req_ready != '0)
                check("req_ready_onehot", 64'($countones(req_ready) == 1 && (req_ready & ~req_valid) == '0), 64'd1);
            if (wb_cyc && !prev_cyc) begin
                if (bus_exp.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL bus_spurious: got access adr=0x%08h, required none", wb_adr);
                    exp_len = 0;
                end else begin
                    b = bus_exp.pop_front();
                    $display("[TB] bus %s adr=0x%08h dat_w=0x%08h sel=0x%0h", wb_we ? "WR" : "RD", wb_adr, wb_dat_w, wb_sel);
                    check("bus_adr", 64'(wb_adr), 64'(b.adr));
                    check("bus_we_sel_stb", {wb_we, wb_sel, wb_stb}, {b.we, b.sel, 1'b1});
                    if (b.we) check("bus_dat_w", 64'(wb_dat_w), 64'(b.dat));
                    exp_len = b.len;
                end
                len = 0;
            end
            if (wb_cyc) len++;
            if (!wb_cyc && prev_cyc && exp_len != 0) check("bus_cyc_len", 64'(len), 64'(exp_len));
            prev_cyc = wb_cyc;
            if ((rsp_valid & rsp_rdy) != '0) begin
                p = 0;
                for (int i = 0; i < N; i++) if (rsp_valid[i]) p = i;
                $display("[TB] rsp port %0d dat=0x%08h status=%0d", p, rsp_dat, rsp_status);
                check("rsp_onehot", 64'($countones(rsp_valid)), 64'd1);
                if (rsp_exp.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL rsp_spurious: got response on port %0d, required none", p);
                end else begin
                    r = rsp_exp.pop_front();
                    check("rsp_port", 64'(p), 64'(r.port));
                    check("rsp_dat", 64'(rsp_dat), 64'(r.dat));
                    check("rsp_status", 64'(rsp_status), 64'(r.status));
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [AW-1:0] a;
        rsp_rdy = '1; inj_ack = 1'b0;
        slave_mode = M_ACK; slave_delay = 1; slave_rdata = '0; slave_rd_adr = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_ctrl", {req_ready, rsp_valid, wb_cyc, wb_stb, wb_we, rsp_status}, '0);
        check("rst_wb_adr_sel", {wb_adr, wb_sel}, '0);
        check("rst_dat", {wb_dat_w, rsp_dat}, '0);
        @(negedge clock);
        reset_n = 1'b1;

        // Read on port 0, ack on the third bus cycle.
        slave_mode = M_ACK; slave_delay = 3; slave_rdata = 32'hDEADBEEF;
        push_cmd(0, 1'b0, 32'h10, 32'h0, 4'hF, 3, 1, 32'hDEADBEEF, 2'd0);
        wait_quiet("t_read");

        // Write on port 1: read data bus ignored, response data is zero.
        slave_delay = 1; slave_rdata = 32'hCAFEF00D;
        push_cmd(1, 1'b1, 32'h20, 32'h12345678, 4'hF, 1, 1, 32'h0, 2'd0);
        wait_quiet("t_write");

        // Timeout on port 2, response held while a late ack arrives.
        slave_mode = M_NONE; rsp_rdy[2] = 1'b0;
        push_cmd(2, 1'b0, 32'h30, 32'h0, 4'hF, TO, 1, 32'h0, 2'd2);
        wait_cyc(1'b1, "t_to_cyc_rise");
        wait_cyc(1'b0, "t_to_cyc_fall");
        repeat (4) @(posedge clock);
        #1 inj_ack = 1'b1;
        @(posedge clock);
        #1 inj_ack = 1'b0;
        check("t_to_rsp_held", {rsp_valid, rsp_status, rsp_dat}, {4'b0100, 2'd2, 32'h0});
        repeat (2) @(posedge clock);
        #1 rsp_rdy[2] = 1'b1;
        wait_quiet("t_timeout");
        inj_ack = 1'b1;
        @(posedge clock);
        #1 inj_ack = 1'b0;
        repeat (3) @(posedge clock);
        #1 check("t_late_ack_idle", {wb_cyc, rsp_valid}, '0);

        // ack and err together: err wins.
        slave_mode = M_ACKERR; slave_delay = 2; slave_rdata = 32'h11111111;
        push_cmd(3, 1'b0, 32'h40, 32'h0, 4'hF, 2, 1, 32'h0, 2'd1);
        wait_quiet("t_ackerr");

        // ack on the last counted cycle beats the timeout.
        slave_mode = M_ACK; slave_delay = TO; slave_rdata = 32'hA5A50F0F;
        push_cmd(0, 1'b0, 32'h50, 32'h0, 4'h3, TO, 1, 32'hA5A50F0F, 2'd0);
        wait_quiet("t_ack_last");

        slave_mode = M_ERR; slave_delay = 1;
        push_cmd(1, 1'b1, 32'h60, 32'hFFFF0000, 4'hC, 1, 1, 32'h0, 2'd1);
        wait_quiet("t_err");

        // Reset in the middle of a bus access on port 2.
        slave_mode = M_NONE;
        push_cmd(2, 1'b0, 32'h70, 32'h0, 4'hF, 0, 0, 32'h0, 2'd0);
        wait_cyc(1'b1, "t_rst_cyc_rise");
        repeat (4) @(posedge clock);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1 check("t_rst_async", {wb_cyc, wb_stb, rsp_valid}, '0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        slave_mode = M_ACK; slave_delay = 2; slave_rdata = 32'h0BADF00D;
        push_cmd(0, 1'b0, 32'h80, 32'h0, 4'hF, 2, 1, 32'h0BADF00D, 2'd0);
        push_cmd(3, 1'b1, 32'h84, 32'h87654321, 4'h1, 2, 1, 32'h0, 2'd0);
        wait_quiet("t_after_rst");

        // All four ports valid together for two rounds: strict rotation.
        slave_delay = 1; slave_rd_adr = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < N; p++) begin
                a = 32'h100 + 32'(r * 16) + 32'(p * 4);
                push_cmd(p, 1'b0, a, 32'h0, 4'hF, 1, 1, ~a, 2'd0);
            end
        end
        wait_quiet("t_fair");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fwperiph_wb_reg_initiator_arb.md
Name: fwperiph_wb_reg_initiator_arb

Overview:
- Multi-port Wishbone register initiator for the fwperiph DMA bench and SoC glue.
- N independent command ports issue single read/write register accesses; a round-robin arbiter serialises them onto one Wishbone classic master port.
- Returns read data and status (OK/ERR/TIMEOUT) to the originating port.
- Generalises the single register initiator to N channels, configurable width and a bus-hang timeout.

Parameters:
- N_INITIATORS, 2, number of command ports (1..16).
- ADDR_WIDTH, 32, Wishbone address width.
- DATA_WIDTH, 32, data width; multiple of 8.
- TIMEOUT, 256, cycles in BUS without ack/err before the access is aborted (>=2).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_INITIATORS  per-port command valid.
- req_ready  out  N_INITIATORS  per-port command accept (one-hot or zero).
- req_we  in  N_INITIATORS  1=write, 0=read.
- req_adr  in  N_INITIATORS*ADDR_WIDTH  flattened addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_dat  in  N_INITIATORS*DATA_WIDTH  flattened write data.
- req_sel  in  N_INITIATORS*DATA_WIDTH/8  flattened byte selects.
- rsp_valid  out  N_INITIATORS  per-port response valid.
- rsp_ready  in  N_INITIATORS  per-port response accept.
- rsp_dat  out  DATA_WIDTH  read data, shared, qualified by rsp_valid.
- rsp_status  out  2  0=OK, 1=ERR, 2=TIMEOUT.
- wb_adr  out  ADDR_WIDTH
- wb_dat_w  out  DATA_WIDTH
- wb_dat_r  in  DATA_WIDTH
- wb_sel  out  DATA_WIDTH/8
- wb_we  out  1
- wb_cyc  out  1
- wb_stb  out  1
- wb_ack  in  1
- wb_err  in  1

Behaviour:
- Reset (async assert, sync release): state=IDLE.
  - All outputs 0, including rsp_dat, rsp_status and all wb_* outputs.
  - rr_last=N_INITIATORS-1, so port 0 has first priority.
  - Timeout counter = 0.
- FSM states: IDLE, BUS, RSP.
- IDLE:
  - If any req_valid is set, grant g = first set bit searching from rr_last+1, wrapping modulo N.
  - req_ready[g]=1 combinationally in this cycle; all other req_ready bits are 0. req_ready is 0 in BUS and RSP.
  - On that edge: capture adr/dat/sel/we of g onto the wb_* registers, set wb_cyc=wb_stb=1, clear the counter, and go to BUS.
  - Issue latency: one cycle from accept to wb_cyc visible.
- BUS:
  - wb outputs are held stable. Counter increments each cycle.
  - wb_ack=1: capture wb_dat_r (reads only; writes return 0), status=OK.
  - wb_err=1: status=ERR, rsp_dat=0. If ack and err are sampled high in the same cycle, err wins.
  - Counter reaches TIMEOUT-1 with no ack/err: status=TIMEOUT, rsp_dat=0. An ack or err in that same cycle wins over the timeout.
  - On any of these terminations: drop wb_cyc/wb_stb on the edge and go to RSP.
- RSP:
  - rsp_valid[g]=1 (one-hot), rsp_dat and rsp_status held.
  - When rsp_ready[g]=1 on an edge: clear rsp_valid, set rr_last=g, go to IDLE.
  - Back-to-back throughput: accept, BUS (>=1), RSP (>=1).
- Fairness: with all ports continuously valid, grants rotate 0,1,...,N-1,0.
- A port deasserting req_valid before its grant is simply skipped. Commands are never partially consumed.
- Late bus responses:
  - wb_ack/wb_err arriving in IDLE or RSP (e.g. after a timeout) are ignored.
  - No new access starts until RSP completes.
- Reset mid-access: bus is abandoned immediately (wb_cyc=0) and the pending response is lost.
- N_INITIATORS=1: arbiter degenerates; the same timing rules apply.

Decomposition:
- Shared package fwperiph_wb_reg_initiator_pkg:
  - rsp_status_e enum (OK=2'd0, ERR=2'd1, TIMEOUT=2'd2).
  - state_e enum (IDLE, BUS, RSP).
  - Counter-width function $clog2(TIMEOUT).
- One sub-module, fwperiph_rr_arbiter:
  - Parameter N; inputs req[N], last[$clog2(N)].
  - Outputs gnt one-hot, gnt_idx, any.
  - Purely combinational; rr_last is held in the parent.

Test Plan:
- Single read, port 0: adr=0x10, slave acks after 3 cycles with 0xDEADBEEF -> wb_cyc high for 3 cycles, rsp_valid[0]=1, rsp_dat=0xDEADBEEF, status=OK.
- Write, port 1: adr=0x20, dat=0x12345678, sel=0xF, ack after 1 cycle -> wb_we=1, wb_dat_w=0x12345678, rsp_valid[1], status=OK, rsp_dat=0.
- N=4, all ports valid continuously for 8 accesses -> grant order 0,1,2,3,0,1,2,3; no port starves.
- Slave never acks, TIMEOUT=16 -> wb_cyc drops after 16 cycles, status=TIMEOUT; a late ack 5 cycles later is ignored.
- ack and err in same cycle -> status=ERR. ack on cycle TIMEOUT-1 -> status=OK.
- reset_n pulsed low while in BUS -> wb_cyc=0 and rsp_valid=0 asynchronously; the next grant goes to port 0.
